// File: rtl/forward_ctrl.sv
// forward_ctrl: EX-stage operand forwarding selects and load-use stall detection
// for a 5-stage pipeline with a 32-entry register file (X31 reads as zero).
module forward_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_rn_used,
  input  logic       id_rm_used,
  input  logic       id_use_imm,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_valid,
  input  logic       flush,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic       stall
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(3);

  // EX stage bookkeeping (instruction currently executing)
  logic             ex_valid;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;

  // MEM stage bookkeeping (instruction one stage older)
  logic             mem_valid;
  logic [REG_W-1:0] mem_rd;
  logic             mem_reg_write;

  logic             rn_ex_hit;
  logic             rn_mem_hit;
  logic             rm_ex_hit;
  logic             rm_mem_hit;
  logic             issue;
  logic [SEL_W-1:0] sel_a_nxt;
  logic [SEL_W-1:0] sel_b_nxt;

  // A stage can supply a source only if it really writes that register and it is not XZR
  function automatic logic hit(input logic [REG_W-1:0] src, input logic used,
                               input logic stg_valid, input logic stg_rw,
                               input logic [REG_W-1:0] stg_rd);
    return used && (src != XZR) && stg_valid && stg_rw && (stg_rd == src);
  endfunction

  // Hazard detection, stall request and next-cycle select computation
  always_comb begin
    rn_ex_hit  = hit(id_rn, id_rn_used, ex_valid, ex_reg_write, ex_rd);
    rn_mem_hit = hit(id_rn, id_rn_used, mem_valid, mem_reg_write, mem_rd);
    rm_ex_hit  = hit(id_rm, id_rm_used, ex_valid, ex_reg_write, ex_rd);
    rm_mem_hit = hit(id_rm, id_rm_used, mem_valid, mem_reg_write, mem_rd);

    // rm is ignored when operand B comes from the immediate
    stall = reset_n && id_valid && !flush && ex_mem_read &&
            (rn_ex_hit || (!id_use_imm && rm_ex_hit));

    issue = id_valid && !flush && !stall;

    sel_a_nxt = SEL_RF;
    if (rn_ex_hit)       sel_a_nxt = SEL_EX;
    else if (rn_mem_hit) sel_a_nxt = SEL_MEM;

    sel_b_nxt = SEL_RF;
    if (id_use_imm)      sel_b_nxt = SEL_IMM;
    else if (rm_ex_hit)  sel_b_nxt = SEL_EX;
    else if (rm_mem_hit) sel_b_nxt = SEL_MEM;
  end

  // Pipeline tracking and registered selects; non-issuing cycles become bubbles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      sel_a         <= SEL_RF;
      sel_b         <= SEL_RF;
    end else begin
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      if (issue) begin
        ex_valid     <= 1'b1;
        ex_rd        <= id_rd;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        sel_a        <= sel_a_nxt;
        sel_b        <= sel_b_nxt;
      end else begin
        ex_valid     <= 1'b0;
        ex_mem_read  <= 1'b0;
        sel_a        <= SEL_RF;
        sel_b        <= SEL_RF;
      end
    end
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: directed vector table, hand-written corner sequence and
// randomized traffic checked against a history-based reference model.
module tb_forward_ctrl;

  logic       clk;
  logic       reset_n;
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic       id_rn_used;
  logic       id_rm_used;
  logic       id_use_imm;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_valid;
  logic       flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;

  int n_vec  = 0;
  int n_miss = 0;

  forward_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rn_used   (id_rn_used),
    .id_rm_used   (id_rm_used),
    .id_use_imm   (id_use_imm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_valid     (id_valid),
    .flush        (flush),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of ID inputs plus the stall expected now and selects expected after the edge
  typedef struct {
    logic       rst_n;
    logic       valid;
    logic       flush;
    logic [4:0] rn;
    logic       rn_used;
    logic [4:0] rm;
    logic       rm_used;
    logic       imm;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
  } vec_t;

  // Reference model: list of what occupied each pipeline slot, newest first
  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } slot_t;

  slot_t hist[$];

  function automatic vec_t mk(input logic rst_n, input logic valid, input logic fl,
                              input int rn, input logic ru, input int rm, input logic mu,
                              input logic imm, input int rd, input logic rw, input logic mr,
                              input logic es, input int ea, input int eb);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.flush = fl;
    v.rn = 5'(rn); v.rn_used = ru; v.rm = 5'(rm); v.rm_used = mu; v.imm = imm;
    v.rd = 5'(rd); v.rw = rw; v.mr = mr;
    v.es = es; v.ea = 2'(ea); v.eb = 2'(eb);
    return v;
  endfunction

  // Age of the newest in-flight writer of r (0 = EX, 1 = MEM), -1 if none
  function automatic int age_of(input logic [4:0] r, input logic used);
    if (!used || r == 5'd31) return -1;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].v && hist[i].rw && hist[i].rd == r) return i;
    return -1;
  endfunction

  function automatic logic model_stall(input vec_t v);
    int an;
    int am;
    an = age_of(v.rn, v.rn_used);
    am = v.imm ? -1 : age_of(v.rm, v.rm_used);
    return v.rst_n && v.valid && !v.flush && hist[0].mr && (an == 0 || am == 0);
  endfunction

  function automatic logic [1:0] sel_for_age(input int age);
    if (age == 0) return 2'd1;
    if (age == 1) return 2'd2;
    return 2'd0;
  endfunction

  // Fill in the model's expectations for a stimulus vector
  function automatic vec_t model_expect(input vec_t vin);
    vec_t v;
    logic issue;
    v = vin;
    v.es = model_stall(v);
    issue = v.rst_n && v.valid && !v.flush && !v.es;
    v.ea = issue ? sel_for_age(age_of(v.rn, v.rn_used)) : 2'd0;
    v.eb = !issue ? 2'd0 : (v.imm ? 2'd3 : sel_for_age(age_of(v.rm, v.rm_used)));
    return v;
  endfunction

  task automatic model_edge(input vec_t v);
    slot_t s;
    if (!v.rst_n) begin
      hist.delete();
      s = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
      hist.push_back(s);
      hist.push_back(s);
    end else begin
      s.v  = v.valid && !v.flush && !model_stall(v);
      s.rd = v.rd;
      s.rw = v.rw;
      s.mr = s.v && v.mr;
      hist.push_front(s);
      void'(hist.pop_back());
    end
  endtask

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  // Drive one ID cycle, check stall before the edge and selects after it
  task automatic apply(input vec_t v, input int idx);
    reset_n      = v.rst_n;
    id_valid     = v.valid;
    flush        = v.flush;
    id_rn        = v.rn;
    id_rn_used   = v.rn_used;
    id_rm        = v.rm;
    id_rm_used   = v.rm_used;
    id_use_imm   = v.imm;
    id_rd        = v.rd;
    id_reg_write = v.rw;
    id_mem_read  = v.mr;
    #1;
    check("stall", idx, int'(stall), int'(v.es));
    @(posedge clk);
    #1;
    check("sel_a", idx, int'(sel_a), int'(v.ea));
    check("sel_b", idx, int'(sel_b), int'(v.eb));
    model_edge(v);
  endtask

  localparam int NTBL = 26;
  vec_t tbl[NTBL];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    vec_t prev;
    logic prev_stall;

    //            rst val fl  rn ru  rm mu im  rd rw mr  es ea eb
    tbl[0]  = mk(0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);  // reset state
    tbl[1]  = mk(1, 1, 0,  5, 1,  6, 1, 0,  1, 1, 0,  0, 0, 0);  // ADD X1
    tbl[2]  = mk(1, 1, 0,  1, 1,  7, 1, 0,  8, 1, 0,  0, 1, 0);  // SUB uses X1 -> EX
    tbl[3]  = mk(1, 1, 0,  9, 1, 10, 1, 0,  2, 1, 0,  0, 0, 0);  // producer X2
    tbl[4]  = mk(1, 1, 0, 12, 1, 13, 1, 0, 11, 1, 0,  0, 0, 0);  // unrelated
    tbl[5]  = mk(1, 1, 0, 14, 1,  2, 1, 0, 15, 1, 0,  0, 0, 2);  // rm=X2 -> MEM
    tbl[6]  = mk(1, 1, 0, 16, 1,  0, 0, 0,  3, 1, 1,  0, 0, 0);  // LDUR X3
    tbl[7]  = mk(1, 1, 0,  3, 1, 17, 1, 0, 18, 1, 0,  1, 0, 0);  // load-use stall
    tbl[8]  = mk(1, 1, 0,  3, 1, 17, 1, 0, 18, 1, 0,  0, 2, 0);  // replay -> MEM
    tbl[9]  = mk(1, 1, 0, 19, 1, 20, 1, 0, 31, 1, 0,  0, 0, 0);  // writes XZR
    tbl[10] = mk(1, 1, 0, 31, 1, 31, 1, 1, 21, 1, 0,  0, 0, 3);  // XZR + imm
    tbl[11] = mk(1, 1, 0, 22, 1,  0, 0, 0,  4, 1, 1,  0, 0, 0);  // LDUR X4
    tbl[12] = mk(1, 1, 1,  4, 1,  0, 0, 0, 24, 1, 0,  0, 0, 0);  // flush beats stall
    tbl[13] = mk(1, 1, 0,  4, 1,  0, 0, 0, 24, 1, 0,  0, 2, 0);  // EX bubble, load in MEM
    tbl[14] = mk(1, 1, 0, 23, 1,  0, 0, 0,  5, 1, 0,  0, 0, 0);  // producer X5
    tbl[15] = mk(1, 1, 0, 25, 1, 26, 1, 0,  5, 1, 0,  0, 0, 0);  // producer X5 again
    tbl[16] = mk(1, 1, 0,  5, 1,  5, 1, 0,  7, 1, 0,  0, 1, 1);  // newer producer wins
    tbl[17] = mk(1, 1, 0, 27, 1,  0, 0, 0,  6, 1, 1,  0, 0, 0);  // LDUR X6
    tbl[18] = mk(0, 1, 0,  6, 1,  7, 1, 0,  9, 1, 0,  0, 0, 0);  // reset mid-stream
    tbl[19] = mk(1, 1, 0,  6, 1,  7, 1, 0,  8, 1, 0,  0, 0, 0);  // old rd not forwarded
    tbl[20] = mk(1, 1, 0, 28, 1,  0, 0, 0, 31, 1, 0,  0, 0, 0);  // writes XZR
    tbl[21] = mk(1, 1, 0, 31, 1, 31, 1, 0, 10, 1, 0,  0, 0, 0);  // XZR never forwarded
    tbl[22] = mk(1, 1, 0, 29, 1,  0, 0, 0,  9, 1, 0,  0, 0, 0);  // producer X9
    tbl[23] = mk(1, 1, 0,  9, 0,  9, 0, 0, 12, 1, 0,  0, 0, 0);  // unused sources
    tbl[24] = mk(1, 1, 0, 30, 1,  0, 0, 0, 13, 1, 1,  0, 0, 0);  // LDUR X13
    tbl[25] = mk(1, 0, 0, 13, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0);  // idle slot, no stall

    model_edge(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < NTBL; i++) apply(tbl[i], i);

    // rm hidden behind immediate must not stall on a load, then reaches MEM
    apply(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0), 100);
    apply(mk(1, 1, 0, 16, 1, 0, 0, 0,  3, 1, 1,  0, 0, 0), 101);
    apply(mk(1, 1, 0, 12, 1, 3, 1, 1, 20, 1, 0,  0, 0, 3), 102);
    apply(mk(1, 1, 0, 14, 1, 3, 1, 0, 21, 1, 0,  0, 0, 2), 103);

    // Randomized traffic against the reference model; stalled inputs are held
    prev_stall = 1'b0;
    prev = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [4:0] pool [4];
      pool[0] = 5'd1; pool[1] = 5'd2; pool[2] = 5'd3; pool[3] = 5'd31;
      if (prev_stall) begin
        v = prev;
      end else begin
        v.valid   = ($urandom_range(7) != 0);
        v.rn      = pool[$urandom_range(3)];
        v.rm      = pool[$urandom_range(3)];
        v.rd      = pool[$urandom_range(3)];
        v.rn_used = ($urandom_range(5) != 0);
        v.rm_used = ($urandom_range(5) != 0);
        v.imm     = ($urandom_range(3) == 0);
        v.rw      = ($urandom_range(4) != 0);
        v.mr      = ($urandom_range(2) == 0);
      end
      v.rst_n = ($urandom_range(49) != 0);
      v.flush = ($urandom_range(9) == 0);
      v = model_expect(v);
      apply(v, 1000 + i);
      prev = v;
      prev_stall = v.es;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have no parameters; datapath register index width fixed at 5, X31 = zero register (XZR).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports id_rn, id_rm  input  5 each  source register indices of the instruction in ID.
REQ-005 SHALL have ports id_rn_used, id_rm_used  input  1 each  source actually read.
REQ-006 SHALL have port id_use_imm  input  1  operand B is the immediate.
REQ-007 SHALL have ports id_rd  input  5, id_reg_write  input  1, id_mem_read  input  1  destination info of the ID instruction.
REQ-008 SHALL have ports id_valid  input  1, flush  input  1  ID slot holds a real instruction / kill the ID instruction.
REQ-009 SHALL have ports sel_a, sel_b  output  2 each  registered selects for the two EX-stage 4:1 x32 operand muxes.
REQ-010 SHALL have port stall  output  1  combinational load-use stall request to PC/IF/ID.

Function
REQ-011 SHALL use select encoding: 00 register-file data, 01 EX/MEM result, 10 MEM/WB result, 11 immediate (sel_b only; sel_a never 11).
REQ-012 SHALL track two internal stages: EX {valid, rd, reg_write, mem_read} and MEM {valid, rd, reg_write}.
REQ-013 SHALL define a hit on stage S for source r as: r used, r != 31, S.valid, S.reg_write, S.rd == r.
REQ-014 SHALL drive stall = 1 when id_valid, flush = 0, reset_n = 1, and a source (rn, or rm when id_use_imm = 0) hits EX with EX.mem_read = 1; else 0.
REQ-015 SHALL, per edge with no stall, no flush, id_valid = 1: load EX from id_*, copy previous EX into MEM, and register sel_a/sel_b from the ID instruction.
REQ-016 SHALL compute each select with priority: immediate (sel_b, id_use_imm) > EX hit -> 01 > MEM hit -> 10 > 00.
REQ-017 SHALL, on a stall edge, insert a bubble: EX.valid <= 0, sel_a/sel_b <= 00, MEM <= previous EX; ID inputs are held upstream and re-evaluated.
REQ-018 SHALL, on flush = 1 or id_valid = 0, insert the same bubble as REQ-017; flush overrides stall (stall = 0).
REQ-019 SHALL make select latency exactly 1 cycle: selects apply to the instruction in EX during the cycle after it was in ID.
REQ-020 SHALL never forward X31: a source of 31 always yields 00 (sel_b 11 if id_use_imm).
REQ-021 SHALL forward only the newer producer when EX and MEM both hit the same register (01).
REQ-022 SHALL give the post-stall re-evaluation of a load-use consumer 10 (load now in MEM), with no second stall.
REQ-023 SHALL keep the design at the stated 1-cycle bubble; no multi-cycle stall counter.

Reset
REQ-024 SHALL, while reset_n = 0 at a rising edge, clear EX.valid, MEM.valid, all stored rd/flags, sel_a = 00, sel_b = 00.
REQ-025 SHALL hold stall = 0 combinationally while reset_n = 0.
REQ-026 SHALL discard in-flight stage contents on reset mid-operation; first instruction after reset sees no forwarding (00).

Verification
REQ-027 SHALL cover back-to-back: ADD X1 (rd=1, rw) then SUB using rn=1 -> next cycle sel_a = 01, stall = 0.
REQ-028 SHALL cover distance-2: producer rd=2, one unrelated instruction, consumer rm=2, id_use_imm=0 -> sel_b = 10.
REQ-029 SHALL cover load-use: LDUR rd=3 (mem_read) then consumer rn=3 -> stall = 1 for 1 cycle, sel_a = 00 bubble, then sel_a = 10, stall = 0.
REQ-030 SHALL cover XZR and immediate: producer rd=31 rw, consumer rn=31, id_use_imm=1 -> sel_a = 00, sel_b = 11.
REQ-031 SHALL cover flush during load-use: flush = 1 with stall condition -> stall = 0, next sel_a/sel_b = 00, EX bubble.
REQ-032 SHALL cover reset mid-stream: reset_n = 0 for 1 edge with producers in EX and MEM -> sel 00, stall 0; consumer of old rd afterwards gets 00.
